controlador_de_pc: RTL
======================

// Module: controlador_de_pc
// PURPOSE
//   Next-address sequencer for contador_de_programa. Each cycle it picks the address the PC loads:
//   sequential, branch, jump, jump-register, interrupt vector, EPC return or hold.
//   It also runs the run/halt/interrupt/boot-switch FSM and drives the PC's BIOS/disk reset pulses.
//   Sits between decode/control and the PC register; it has no instruction memory access.
// PARAMETERS
//   LARGURA_PC   26   PC / address width (word addresses)
//   VETOR_BOOT   0    address forced during reset and boot switch
// PORTS
//   clock         in   1   single system clock, rising edge
//   reset_n       in   1   reset; asynchronous, active-low
//   pc_atual      in   26  current PC value
//   stall         in   1   pipeline/memory wait; hold PC
//   halt          in   1   HLT decoded
//   branch_taken  in   1   conditional branch resolved taken
//   branch_alvo   in   26  branch target
//   jump          in   1   J/JAL
//   jump_alvo     in   26  jump target
//   jump_reg      in   1   JR/JALR
//   reg_alvo      in   26  register target
//   irq           in   1   level interrupt request, held by source until serviced
//   irq_vetor     in   26  handler address
//   eret          in   1   return from interrupt
//   boot_bios     in   1   request restart into BIOS
//   boot_disk     in   1   request restart into disk-loaded program
//   endereco      out  26  next PC (combinational; PC captures at posedge clock)
//   bios_reset    out  1   registered one-cycle pulse to PC
//   disk_reset    out  1   registered one-cycle pulse to PC
//   epc           out  26  saved return address
//   int_ativo     out  1   high while in S_INT
//   estado        out  2   FSM state
// BEHAVIOUR
//   - Reset (reset_n=0): estado=S_RUN, epc=0, int_ativo=0, pulses=0, endereco=VETOR_BOOT.
//   - States: S_RUN=0, S_INT=1, S_HALT=2, S_TROCA=3. State, epc and pulses are registered.
//   - Sequential address = pc_atual+1, truncated to LARGURA_PC; 26'h3FFFFFF wraps to 0.
//   - Priority in S_RUN, highest first:
//       stall -> endereco=pc_atual; no state change; all requests ignored this cycle.
//       boot_bios -> S_TROCA, bios_reset=1 next cycle.
//       boot_disk -> S_TROCA, disk_reset=1 next cycle. bios wins if both are set.
//       irq -> endereco=irq_vetor; epc<=address otherwise chosen by halt..seq below; S_INT.
//       halt -> endereco=pc_atual; go to S_HALT.
//       jump_reg -> reg_alvo; jump -> jump_alvo; branch_taken -> branch_alvo.
//       otherwise -> sequential.
//   - S_INT: same as S_RUN except irq is ignored (no nesting).
//     eret (no stall) -> endereco=epc, go to S_RUN. eret has priority over halt/jumps.
//   - S_HALT: endereco=pc_atual.
//     irq -> endereco=irq_vetor, epc<=pc_atual+1, go to S_INT.
//     boot_* -> S_TROCA. Other inputs are ignored.
//   - S_TROCA: lasts exactly 1 cycle. Pulse is high only in this cycle; endereco=VETOR_BOOT;
//     epc and int_ativo are cleared; next state S_RUN. Requests arriving in S_TROCA are dropped.
//   - eret in S_RUN and S_HALT has no effect. Multiple flow flags at once are resolved by priority only.
//   - reset_n low mid-operation: immediate async return to reset values, including
//     killing a pulse already in flight.
// STRUCTURE
//   - Package izero_pc_pkg: LARGURA_PC, VETOR_BOOT, state encodings S_RUN/S_INT/S_HALT/S_TROCA.
//   - Sub-module seletor_proximo_pc: pure combinational priority mux for
//     halt/jump_reg/jump/branch/seq. Its output is the epc candidate.
//   - Top: FSM, epc register, pulse registers, irq/eret/stall override.
// TESTING
//   1. Reset, pc_atual=0x10, no flags -> endereco=0x11, estado=0, pulses 0.
//   2. pc_atual=0x3FFFFFF, no flags -> endereco=0.
//   3. jump=1 (0x200), branch_taken=1 (0x300) together -> 0x200.
//      Add jump_reg=1 (0x400) -> 0x400.
//   4. pc_atual=0x40, irq=1, irq_vetor=0x80 -> endereco=0x80; next cycle epc=0x41, int_ativo=1.
//      irq held -> ignored. eret -> endereco=0x41, estado=S_RUN.
//   5. halt at pc 0x50 -> endereco=0x50 every cycle. irq -> 0x80, epc=0x51.
//   6. boot_bios+boot_disk together -> 1 cycle bios_reset=1, disk_reset=0, endereco=0, then S_RUN.
//      stall=1 with irq/boot_bios -> endereco=pc_atual, no transition.
//      reset_n low during S_TROCA -> pulse drops at once.

Source files
------------

// File: rtl/izero_pc_pkg.sv
// ---------------------------------------------------------------------------
// izero_pc_pkg
//   Shared definitions for the PC next-address sequencer.
//   - LARGURA_PC / VETOR_BOOT : address width and boot vector
//   - estado_t                : run/interrupt/halt/boot-switch FSM encoding
//   - acao_t                  : per-cycle action chosen by the priority logic
//   - incrementa()            : sequential address, wrapping at LARGURA_PC
// ---------------------------------------------------------------------------
package izero_pc_pkg;

  localparam int                    LARGURA_PC = 26;
  localparam logic [LARGURA_PC-1:0] VETOR_BOOT = '0;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_INT   = 2'd1,
    S_HALT  = 2'd2,
    S_TROCA = 2'd3
  } estado_t;

  // What the FSM does at the next clock edge, decided combinationally.
  typedef enum logic [2:0] {
    A_HOLD,      // keep state (stall, or nothing to do while halted)
    A_FLUXO,     // normal flow: stay in current state
    A_BIOS,      // enter S_TROCA and pulse bios_reset
    A_DISK,      // enter S_TROCA and pulse disk_reset
    A_IRQ,       // enter S_INT, save return address
    A_ERET,      // leave S_INT
    A_HALT,      // enter S_HALT
    A_BOOT_FIM   // S_TROCA finished, back to S_RUN
  } acao_t;

  function automatic logic [LARGURA_PC-1:0] incrementa(input logic [LARGURA_PC-1:0] pc);
    return pc + LARGURA_PC'(1);
  endfunction

endpackage

// File: rtl/seletor_proximo_pc.sv
// ---------------------------------------------------------------------------
// seletor_proximo_pc
//   Pure combinational priority mux for ordinary program flow.
//   Priority: halt > jump_reg > jump > branch_taken > sequential.
//   Its output is both the normal next address and the return address
//   saved in epc when an interrupt is taken from S_RUN.
// Ports
//   pc_atual                  in  current PC
//   halt                      in  HLT decoded (hold pc_atual)
//   jump_reg / reg_alvo       in  JR/JALR and its target
//   jump / jump_alvo          in  J/JAL and its target
//   branch_taken / branch_alvo in taken branch and its target
//   proximo                   out selected address
// ---------------------------------------------------------------------------
module seletor_proximo_pc
  import izero_pc_pkg::*;
(
  input  logic [LARGURA_PC-1:0] pc_atual,
  input  logic                  halt,
  input  logic                  jump_reg,
  input  logic [LARGURA_PC-1:0] reg_alvo,
  input  logic                  jump,
  input  logic [LARGURA_PC-1:0] jump_alvo,
  input  logic                  branch_taken,
  input  logic [LARGURA_PC-1:0] branch_alvo,
  output logic [LARGURA_PC-1:0] proximo
);

  always_comb begin
    if (halt)              proximo = pc_atual;
    else if (jump_reg)     proximo = reg_alvo;
    else if (jump)         proximo = jump_alvo;
    else if (branch_taken) proximo = branch_alvo;
    else                   proximo = incrementa(pc_atual);
  end

endmodule

// File: rtl/controlador_de_pc.sv
// ---------------------------------------------------------------------------
// controlador_de_pc
//   Next-address sequencer for contador_de_programa. Chooses the address the
//   PC loads each cycle and runs the run/interrupt/halt/boot-switch FSM.
// Ports
//   clock, reset_n            in  clock (rising edge), async active-low reset
//   pc_atual                  in  current PC
//   stall                     in  hold PC, ignore every request this cycle
//   halt, branch_taken/alvo, jump/alvo, jump_reg/reg_alvo  in  flow requests
//   irq / irq_vetor           in  level interrupt and handler address
//   eret                      in  return from interrupt
//   boot_bios, boot_disk      in  restart requests
//   endereco                  out next PC (combinational)
//   bios_reset, disk_reset    out registered one-cycle pulses (S_TROCA only)
//   epc                       out saved return address
//   int_ativo                 out high while in S_INT
//   estado                    out FSM state
// ---------------------------------------------------------------------------
module controlador_de_pc
  import izero_pc_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [LARGURA_PC-1:0] pc_atual,
  input  logic                  stall,
  input  logic                  halt,
  input  logic                  branch_taken,
  input  logic [LARGURA_PC-1:0] branch_alvo,
  input  logic                  jump,
  input  logic [LARGURA_PC-1:0] jump_alvo,
  input  logic                  jump_reg,
  input  logic [LARGURA_PC-1:0] reg_alvo,
  input  logic                  irq,
  input  logic [LARGURA_PC-1:0] irq_vetor,
  input  logic                  eret,
  input  logic                  boot_bios,
  input  logic                  boot_disk,
  output logic [LARGURA_PC-1:0] endereco,
  output logic                  bios_reset,
  output logic                  disk_reset,
  output logic [LARGURA_PC-1:0] epc,
  output logic                  int_ativo,
  output logic [1:0]            estado
);

  estado_t               r_estado;
  logic [LARGURA_PC-1:0] r_epc;
  logic                  r_bios_reset;
  logic                  r_disk_reset;
  logic                  r_int_ativo;

  logic [LARGURA_PC-1:0] w_candidato;
  logic [LARGURA_PC-1:0] w_epc_cand;
  logic [LARGURA_PC-1:0] w_endereco;
  acao_t                 w_acao;

  seletor_proximo_pc u_seletor (
    .pc_atual     (pc_atual),
    .halt         (halt),
    .jump_reg     (jump_reg),
    .reg_alvo     (reg_alvo),
    .jump         (jump),
    .jump_alvo    (jump_alvo),
    .branch_taken (branch_taken),
    .branch_alvo  (branch_alvo),
    .proximo      (w_candidato)
  );

  // Priority decode: picks the address and the action for the next edge.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    w_acao     = A_FLUXO;
    w_endereco = w_candidato;
    w_epc_cand = w_candidato;
    if (!reset_n) begin
      w_acao     = A_HOLD;
      w_endereco = VETOR_BOOT;
    end else begin
      unique case (r_estado)
        S_RUN, S_INT: begin
          if (stall) begin
            w_acao     = A_HOLD;
            w_endereco = pc_atual;
          end else if (boot_bios) begin
            w_acao     = A_BIOS;
            w_endereco = pc_atual;
          end else if (boot_disk) begin
            w_acao     = A_DISK;
            w_endereco = pc_atual;
          end else if (irq && (r_estado == S_RUN)) begin
            // No nesting: irq only counts from S_RUN.
            w_acao     = A_IRQ;
            w_endereco = irq_vetor;
          end else if (eret && (r_estado == S_INT)) begin
            w_acao     = A_ERET;
            w_endereco = r_epc;
          end else if (halt) begin
            w_acao     = A_HALT;
            w_endereco = pc_atual;
          end
        end
        S_HALT: begin
          w_acao     = A_HOLD;
          w_endereco = pc_atual;
          // Resume after the halted instruction once the handler returns.
          w_epc_cand = incrementa(pc_atual);
          if (boot_bios) begin
            w_acao = A_BIOS;
          end else if (boot_disk) begin
            w_acao = A_DISK;
          end else if (irq) begin
            w_acao     = A_IRQ;
            w_endereco = irq_vetor;
          end
        end
        S_TROCA: begin
          w_acao     = A_BOOT_FIM;
          w_endereco = VETOR_BOOT;
        end
        default: begin
          w_acao     = A_BOOT_FIM;
          w_endereco = VETOR_BOOT;
        end
      endcase
    end
  end

  // State, epc, interrupt flag and boot pulses.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // Async clear also kills a boot pulse already in flight.
      r_estado     <= S_RUN;
      r_epc        <= '0;
      r_bios_reset <= 1'b0;
      r_disk_reset <= 1'b0;
      r_int_ativo  <= 1'b0;
    end else begin
      // Pulses are high only during the single S_TROCA cycle.
      r_bios_reset <= 1'b0;
      r_disk_reset <= 1'b0;
      unique case (w_acao)
        A_HOLD, A_FLUXO: ;
        A_BIOS: begin
          r_estado     <= S_TROCA;
          r_bios_reset <= 1'b1;
          r_epc        <= '0;
          r_int_ativo  <= 1'b0;
        end
        A_DISK: begin
          r_estado     <= S_TROCA;
          r_disk_reset <= 1'b1;
          r_epc        <= '0;
          r_int_ativo  <= 1'b0;
        end
        A_IRQ: begin
          r_estado    <= S_INT;
          r_epc       <= w_epc_cand;
          r_int_ativo <= 1'b1;
        end
        A_ERET: begin
          r_estado    <= S_RUN;
          r_int_ativo <= 1'b0;
        end
        A_HALT: begin
          r_estado    <= S_HALT;
          r_int_ativo <= 1'b0;
        end
        A_BOOT_FIM: begin
          r_estado    <= S_RUN;
          r_epc       <= '0;
          r_int_ativo <= 1'b0;
        end
        default: r_estado <= S_RUN;
      endcase
    end
  end

  assign endereco   = w_endereco;
  assign bios_reset = r_bios_reset;
  assign disk_reset = r_disk_reset;
  assign epc        = r_epc;
  assign int_ativo  = r_int_ativo;
  assign estado     = r_estado;

endmodule
